// File: rtl/lc3_wait_ram.sv
// LC-3 main memory with a programmable wait-state sequencer.
// Returns a one-cycle ready pulse WAIT_CYCLES edges after an access is accepted.
module lc3_wait_ram #(
  parameter int    ADDR_W      = 16,
  parameter int    DATA_W      = 16,
  parameter int    WAIT_CYCLES = 4,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              r_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic [DATA_W-1:0] data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] din_q;
  logic              accept, enter_done;
  logic [ADDR_W-1:0] eff_addr;
  logic              eff_rw;
  logic [DATA_W-1:0] eff_din;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (cs) begin
        accept     = 1'b1;
        next_state = (WAIT_CYCLES == 1) ? DONE : BUSY;
      end
      BUSY: if (cnt == 4'd1) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With a single wait cycle the access completes on its acceptance edge, so use the live inputs.
  assign eff_addr   = accept ? addr    : addr_q;
  assign eff_rw     = accept ? r_w     : rw_q;
  assign eff_din    = accept ? data_in : din_q;
  assign enter_done = rst && (next_state == DONE) && (state != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      din_q    <= '0;
      ready    <= 1'b0;
      data_out <= '0;
    end else begin
      ready <= enter_done;
      if (accept) begin
        addr_q <= addr;
        rw_q   <= r_w;
        din_q  <= data_in;
        cnt    <= CNT_LOAD;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_done && !eff_rw) data_out <= mem[eff_addr];
    end
  end

  // Array is never reset; a write only lands on the DONE-entry edge.
  always_ff @(posedge clk) begin
    if (enter_done && eff_rw) mem[eff_addr] <= eff_din;
  end

endmodule
